// File: rtl/cache_ctrl_2way_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_2way_if
// Brief    : CPU request/response and memory port bundle for cache_ctrl_2way.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_ctrl_2way_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_ready;
  logic              cpu_hit;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Requester side: CPU plus main memory.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_busy, cpu_ready, cpu_hit, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  // Cache controller side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_busy, cpu_ready, cpu_hit, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_2way.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_2way
// Brief    : 8-set, 2-way set-associative write-back cache controller, LRU.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl_2way #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  cache_ctrl_2way_if.slave   bus
);

  localparam int TAG_W = ADDR_W - 3;
  localparam int SETS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_miss;
  logic                r_victim;
  logic [1:0][SETS-1:0] r_valid;
  logic [1:0][SETS-1:0] r_dirty;
  logic [SETS-1:0]     r_lru;
  logic [TAG_W-1:0]    r_tagArr  [2][SETS];
  logic [DATA_W-1:0]   r_dataArr [2][SETS];

  logic [2:0]          w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hitWay;
  logic                w_victim;
  logic                w_victimDirty;
  logic                w_dataWe;
  logic                w_arrWay;
  logic [DATA_W-1:0]   w_dataVal;
  logic                w_tagWe;

  assign w_idx    = r_addr[2:0];
  assign w_tag    = r_addr[ADDR_W-1:3];
  assign w_hit0   = r_valid[0][w_idx] && (r_tagArr[0][w_idx] == w_tag);
  assign w_hit1   = r_valid[1][w_idx] && (r_tagArr[1][w_idx] == w_tag);
  assign w_hit    = w_hit0 || w_hit1;
  assign w_hitWay = !w_hit0;

  // Prefer an empty way; only when both are live does the LRU bit decide.
  always_comb begin
    w_victim = 1'b0;
    if (!r_valid[0][w_idx])
      w_victim = 1'b0;
    else if (!r_valid[1][w_idx])
      w_victim = 1'b1;
    else
      w_victim = r_lru[w_idx];
  end

  assign w_victimDirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

  assign w_tagWe   = (r_state == REFILL) && bus.mem_ack;
  assign w_dataWe  = w_tagWe || ((r_state == LOOKUP) && w_hit && r_we);
  assign w_arrWay  = (r_state == REFILL) ? r_victim : w_hitWay;
  assign w_dataVal = (r_state == REFILL) ? bus.mem_rdata : r_wdata;

  assign bus.cpu_busy = (r_state != IDLE);

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_dataWe)
      r_dataArr[w_arrWay][w_idx] <= w_dataVal;
    if (w_tagWe)
      r_tagArr[r_victim][w_idx] <= w_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_miss        <= 1'b0;
      r_victim      <= 1'b0;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_lru         <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_hit   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.cpu_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            r_we    <= bus.cpu_we;
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_miss  <= 1'b0;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            if (r_we)
              r_dirty[w_hitWay][w_idx] <= 1'b1;
            else
              bus.cpu_rdata <= r_dataArr[w_hitWay][w_idx];
            r_lru[w_idx]  <= ~w_hitWay;
            bus.cpu_hit   <= ~r_miss;
            bus.cpu_ready <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_miss      <= 1'b1;
            r_victim    <= w_victim;
            bus.mem_req <= 1'b1;
            if (w_victimDirty) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {r_tagArr[w_victim][w_idx], w_idx};
              bus.mem_wdata <= r_dataArr[w_victim][w_idx];
              r_state       <= WRITEBACK;
            end else begin
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= r_addr;
              r_state      <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          // mem_req stays high; the refill address takes over on the ack edge.
          if (bus.mem_ack) begin
            r_dirty[r_victim][w_idx] <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= r_addr;
            r_state      <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            r_valid[r_victim][w_idx] <= 1'b1;
            r_dirty[r_victim][w_idx] <= 1'b0;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            r_state     <= LOOKUP;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Controller for the 2-way set-associative write-back cache.
- Holds tag, valid, dirty, per-set LRU and data arrays (8 sets x 2 ways, one word per line).
- Sequences lookup, victim selection, dirty-line writeback and refill between a single CPU requester and a single memory port.
- Sits between the CPU load/store path and main memory.

Parameters:
ADDR_W, 8, CPU/memory word address width; index = addr[2:0], tag = addr[ADDR_W-1:3]
DATA_W, 8, data word width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  request strobe, sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_busy  out  1  high whenever state != IDLE
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  valid with cpu_ready; 1 = original lookup hit
cpu_rdata  out  DATA_W  read data, valid with cpu_ready
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = writeback, 0 = refill read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  writeback data
mem_ack  in  1  memory done, sampled only while mem_req = 1
mem_rdata  in  DATA_W  refill data, valid with mem_ack

Behaviour:
- Reset:
  - State IDLE; all valid, dirty and LRU bits cleared.
  - Outputs: cpu_busy, cpu_ready, cpu_hit, mem_req, mem_we = 0; cpu_rdata, mem_addr, mem_wdata = 0.
  - Data and tag arrays are not reset.
- All outputs are registered, except cpu_busy, which is decoded from state.
- States are IDLE, LOOKUP, WRITEBACK, REFILL, DONE.
- IDLE: on cpu_req = 1, latch cpu_we, cpu_addr and cpu_wdata, clear the miss flag, and go to LOOKUP.
- LOOKUP (1 cycle): compare the latched tag against both valid ways of set[index].
  - Hit on way w, read: cpu_rdata <= data[w].
  - Hit on way w, write: data[w] <= wdata and dirty[w] <= 1.
  - Any hit: lru[index] <= ~w, cpu_hit <= ~miss flag, cpu_ready <= 1, go to DONE.
  - Miss: set the miss flag and pick victim v:
    - way0 if both ways are invalid;
    - otherwise the single invalid way;
    - otherwise lru[index].
  - Miss with v valid and dirty: go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK:
  - mem_req = 1, mem_we = 1, mem_addr = {tag[v], index}, mem_wdata = data[v].
  - On mem_ack: dirty[v] <= 0, go to REFILL.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = latched address.
  - On mem_ack: data[v] <= mem_rdata, tag[v] <= latched tag, valid[v] <= 1, dirty[v] <= 0, go to LOOKUP.
  - The re-lookup hits and completes the access; a write is merged there.
- DONE: cpu_ready is high for exactly this cycle, then go to IDLE.
- Latency:
  - Hit: cpu_req sampled at edge E0, cpu_ready high in the cycle after E1, IDLE after E2.
  - Miss: adds the memory wait cycles plus one LOOKUP.
- Memory handshake:
  - mem_req rises on the edge entering WRITEBACK or REFILL.
  - mem_addr, mem_we and mem_wdata stay stable until the mem_ack edge.
  - mem_ack is legal in the first cycle mem_req is high.
  - mem_req drops after WRITEBACK->REFILL for one cycle only if required by the state encoding. The required behaviour is continuous mem_req = 1 with mem_we/mem_addr changing on the ack edge.
  - mem_req deasserts on the edge leaving REFILL.
- cpu_req in any state other than IDLE is ignored; there is no queueing.
- LRU convention: lru[i] names the way to evict next. It is updated only on a LOOKUP hit, which includes the post-refill lookup.
- Reset mid-operation: return to IDLE immediately (asynchronous); mem_req drops without waiting for ack; all lines are invalid.

Test Plan:
1. After reset, read 0x25; memory acks 2 cycles after mem_req with 0xA5 -> a single REFILL (mem_we = 0, mem_addr = 0x25), no WRITEBACK; cpu_ready with cpu_rdata = 0xA5, cpu_hit = 0. Read 0x25 again -> cpu_ready 2 edges after accept, cpu_hit = 1, mem_req never rises.
2. Fill set 5: read 0x25, read 0x45 (lands in way1), read 0x25 (hit, lru[5] = 1), read 0x65 -> clean victim way1 (0x45), no WRITEBACK; read 0x25 hits; read 0x45 misses.
3. Write 0x25 with 0x3C (hit, dirty), then read 0x45, then read 0x65 -> WRITEBACK with mem_addr = 0x25, mem_wdata = 0x3C, mem_we = 1, before the REFILL of 0x65. A later read of 0x25 refills and returns the memory model value 0x3C.
4. Write miss to 0x1A with 0x77 -> refill, merge on re-lookup, cpu_hit = 0; read 0x1A -> hit, 0x77.
5. Memory handshake timing:
   - mem_ack held low for 10 cycles -> mem_req, mem_addr and mem_we stable throughout.
   - mem_ack high in the first mem_req cycle -> accepted, one transfer only.
6. Assert rst in the 3rd REFILL cycle -> mem_req = 0 and cpu_busy = 0 before the next clock edge. A following read of 0x25 misses. cpu_req pulses while cpu_busy = 1 produce no extra cpu_ready.
